// File: rtl/rat_ckpt.sv
// -----------------------------------------------------------------------------
// rat_ckpt
// Register alias table with a ring of full-table checkpoints for branch
// recovery. Each accepted group of WIDTH lanes is renamed against the current
// map, with in-group bypass from lower lanes. The table updates in lane order,
// and every branch lane saves a copy of the map (as seen just after its own
// write) into the next free checkpoint slot.
//
// Optional feature:
//   RAT_CKPT_STALL_CNT_EN - when defined, adds a 32-bit saturating stall_cnt
//                           output that counts cycles with in_valid & !in_ready.
//
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready   rename group handshake (fire = in_valid & in_ready)
//   rs1, rs2, rd          per-lane architectural indices (WIDTH*AW)
//   rd_valid, is_br       per-lane destination-write and branch flags
//   free_prd              per-lane new physical register from the free list
//   out_valid             one-cycle pulse with the renamed group
//   prs1, prs2, prd,
//   prev_prd              per-lane renamed physical indices (WIDTH*PW)
//   prev_valid            per-lane flag: prev_prd is meaningful
//   cp_idx                per-lane checkpoint slot (branch lanes)
//   recover, recover_idx  restore the map from a checkpoint slot
//   retire_cp             release the oldest checkpoint
//   cp_count              number of live checkpoints
// -----------------------------------------------------------------------------
module rat_ckpt #(
    parameter int WIDTH    = 2,
    parameter int ARF_N    = 32,
    parameter int PRF_N    = 64,
    parameter int CP_DEPTH = 4,
    localparam int AW      = $clog2(ARF_N),
    localparam int PW      = $clog2(PRF_N),
    localparam int CW      = $clog2(CP_DEPTH)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH*AW-1:0]   rs1,
    input  logic [WIDTH*AW-1:0]   rs2,
    input  logic [WIDTH*AW-1:0]   rd,
    input  logic [WIDTH-1:0]      rd_valid,
    input  logic [WIDTH-1:0]      is_br,
    input  logic [WIDTH*PW-1:0]   free_prd,
    output logic                  out_valid,
    output logic [WIDTH*PW-1:0]   prs1,
    output logic [WIDTH*PW-1:0]   prs2,
    output logic [WIDTH*PW-1:0]   prd,
    output logic [WIDTH*PW-1:0]   prev_prd,
    output logic [WIDTH-1:0]      prev_valid,
    output logic [WIDTH*CW-1:0]   cp_idx,
    input  logic                  recover,
    input  logic [CW-1:0]         recover_idx,
    input  logic                  retire_cp,
    output logic [CW:0]           cp_count
`ifdef RAT_CKPT_STALL_CNT_EN
    ,
    output logic [31:0]           stall_cnt
`endif
);

    localparam logic [CW:0] DEPTH_C = (CW+1)'(CP_DEPTH);

    // Architectural state
    logic [PW-1:0]       r_map [ARF_N];
    logic [PW-1:0]       r_cp  [CP_DEPTH][ARF_N];
    logic [CW-1:0]       r_head;
    logic [CW-1:0]       r_tail;
    logic [CW:0]         r_count;

    // Registered outputs
    logic                r_out_valid;
    logic [WIDTH*PW-1:0] r_prs1;
    logic [WIDTH*PW-1:0] r_prs2;
    logic [WIDTH*PW-1:0] r_prd;
    logic [WIDTH*PW-1:0] r_prev_prd;
    logic [WIDTH-1:0]    r_prev_valid;
    logic [WIDTH*CW-1:0] r_cp_idx;

    // Combinational rename results
    logic [PW-1:0]       w_stage [WIDTH+1][ARF_N];
    logic [WIDTH-1:0]    w_we;
    logic [CW:0]         w_nbr;
    logic [WIDTH*CW-1:0] w_slot;
    logic [WIDTH*PW-1:0] w_prs1;
    logic [WIDTH*PW-1:0] w_prs2;
    logic [WIDTH*PW-1:0] w_prd;
    logic [WIDTH*PW-1:0] w_prev;
    logic                w_fire;
    logic                w_retire;
    logic [CW-1:0]       w_head_n;
    logic [CW-1:0]       w_rec_diff;
    logic [CW:0]         w_rec_count;
    logic [CW:0]         w_count_n;

    // w_stage[i] is the map as lane i sees it: the table with the writes of
    // lanes 0..i-1 already applied. Reading sources from it gives the
    // "highest lower lane wins" bypass for free, and w_stage[i+1] is exactly
    // the snapshot a branch in lane i must save.
    always_comb begin
        for (int s = 0; s <= WIDTH; s++) begin
            w_stage[s] = r_map;
        end
        w_we   = '0;
        w_nbr  = '0;
        w_slot = '0;
        w_prs1 = '0;
        w_prs2 = '0;
        w_prd  = '0;
        w_prev = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_stage[i+1] = w_stage[i];
            // Writes to x0 are dropped so x0 always maps to phys 0.
            w_we[i] = rd_valid[i] && (rd[i*AW +: AW] != '0);
            w_prs1[i*PW +: PW] = (rs1[i*AW +: AW] == '0) ? '0 : w_stage[i][rs1[i*AW +: AW]];
            w_prs2[i*PW +: PW] = (rs2[i*AW +: AW] == '0) ? '0 : w_stage[i][rs2[i*AW +: AW]];
            w_prev[i*PW +: PW] = w_stage[i][rd[i*AW +: AW]];
            w_prd[i*PW +: PW]  = w_we[i] ? free_prd[i*PW +: PW] : '0;
            if (w_we[i]) begin
                w_stage[i+1][rd[i*AW +: AW]] = free_prd[i*PW +: PW];
            end
            // Branch lanes take consecutive slots starting at the tail.
            w_slot[i*CW +: CW] = r_tail + w_nbr[CW-1:0];
            if (is_br[i]) begin
                w_nbr = w_nbr + (CW+1)'(1);
            end
        end
    end

    assign in_ready = !recover && ((DEPTH_C - r_count) >= w_nbr);
    assign w_fire   = in_valid && in_ready;

    // Retire is applied before recovery, so the recovered count is measured
    // from the post-retire head. A zero distance means the ring is full,
    // except when a retire just consumed the recovered slot itself.
    assign w_retire    = retire_cp && (r_count != '0);
    assign w_head_n    = r_head + CW'(w_retire);
    assign w_rec_diff  = recover_idx - w_head_n + CW'(1);
    assign w_rec_count = ((w_rec_diff == '0) && !w_retire) ? DEPTH_C : {1'b0, w_rec_diff};
    assign w_count_n   = r_count - (CW+1)'(w_retire) + (w_fire ? w_nbr : '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int a = 0; a < ARF_N; a++) begin
                r_map[a] <= PW'(a);
                for (int s = 0; s < CP_DEPTH; s++) begin
                    r_cp[s][a] <= PW'(a);
                end
            end
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_out_valid  <= 1'b0;
            r_prs1       <= '0;
            r_prs2       <= '0;
            r_prd        <= '0;
            r_prev_prd   <= '0;
            r_prev_valid <= '0;
            r_cp_idx     <= '0;
        end else begin
            r_out_valid <= w_fire;
            r_head      <= w_head_n;
            if (recover) begin
                r_map   <= r_cp[recover_idx];
                r_tail  <= recover_idx + CW'(1);
                r_count <= w_rec_count;
            end else begin
                r_count <= w_count_n;
                if (w_fire) begin
                    r_map        <= w_stage[WIDTH];
                    r_tail       <= r_tail + w_nbr[CW-1:0];
                    r_prs1       <= w_prs1;
                    r_prs2       <= w_prs2;
                    r_prd        <= w_prd;
                    r_prev_prd   <= w_prev;
                    r_prev_valid <= w_we;
                    r_cp_idx     <= w_slot;
                    for (int i = 0; i < WIDTH; i++) begin
                        if (is_br[i]) begin
                            r_cp[w_slot[i*CW +: CW]] <= w_stage[i+1];
                        end
                    end
                end
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign prs1       = r_prs1;
    assign prs2       = r_prs2;
    assign prd        = r_prd;
    assign prev_prd   = r_prev_prd;
    assign prev_valid = r_prev_valid;
    assign cp_idx     = r_cp_idx;
    assign cp_count   = r_count;

`ifdef RAT_CKPT_STALL_CNT_EN
    logic [31:0] r_stall;

    // Saturating count of cycles where a group is offered but refused.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_stall <= '0;
        end else if (in_valid && !in_ready && (r_stall != '1)) begin
            r_stall <= r_stall + 32'd1;
        end
    end

    assign stall_cnt = r_stall;
`endif

endmodule

// File: tb/tb_rat_ckpt.sv
// -----------------------------------------------------------------------------
// tb_rat_ckpt
// Self-checking bench for rat_ckpt (default parameters). A behavioural model
// renames each lane in order against an integer map, keeps checkpoints as
// plain array copies and tracks head/tail/count with modular arithmetic.
// Directed scenarios come first, followed by randomized groups.
// -----------------------------------------------------------------------------
module tb_rat_ckpt;

    localparam int WIDTH    = 2;
    localparam int ARF_N    = 32;
    localparam int PRF_N    = 64;
    localparam int CP_DEPTH = 4;
    localparam int AW       = 5;
    localparam int PW       = 6;
    localparam int CW       = 2;

    logic                  clock;
    logic                  reset;
    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH*AW-1:0]   rs1;
    logic [WIDTH*AW-1:0]   rs2;
    logic [WIDTH*AW-1:0]   rd;
    logic [WIDTH-1:0]      rd_valid;
    logic [WIDTH-1:0]      is_br;
    logic [WIDTH*PW-1:0]   free_prd;
    logic                  out_valid;
    logic [WIDTH*PW-1:0]   prs1;
    logic [WIDTH*PW-1:0]   prs2;
    logic [WIDTH*PW-1:0]   prd;
    logic [WIDTH*PW-1:0]   prev_prd;
    logic [WIDTH-1:0]      prev_valid;
    logic [WIDTH*CW-1:0]   cp_idx;
    logic                  recover;
    logic [CW-1:0]         recover_idx;
    logic                  retire_cp;
    logic [CW:0]           cp_count;

    rat_ckpt #(
        .WIDTH   (WIDTH),
        .ARF_N   (ARF_N),
        .PRF_N   (PRF_N),
        .CP_DEPTH(CP_DEPTH)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .rs1        (rs1),
        .rs2        (rs2),
        .rd         (rd),
        .rd_valid   (rd_valid),
        .is_br      (is_br),
        .free_prd   (free_prd),
        .out_valid  (out_valid),
        .prs1       (prs1),
        .prs2       (prs2),
        .prd        (prd),
        .prev_prd   (prev_prd),
        .prev_valid (prev_valid),
        .cp_idx     (cp_idx),
        .recover    (recover),
        .recover_idx(recover_idx),
        .retire_cp  (retire_cp),
        .cp_count   (cp_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int mMap [ARF_N];
    int mCp  [CP_DEPTH][ARF_N];
    int mHead, mTail, mCount;
    int ePrs1 [WIDTH];
    int ePrs2 [WIDTH];
    int ePrd  [WIDTH];
    int ePrev [WIDTH];
    int ePv   [WIDTH];
    int eCp   [WIDTH];
    int eBr   [WIDTH];
    int eOv;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        for (int a = 0; a < ARF_N; a++) begin
            mMap[a] = a;
            for (int s = 0; s < CP_DEPTH; s++) mCp[s][a] = a;
        end
        mHead = 0; mTail = 0; mCount = 0; eOv = 0;
        for (int i = 0; i < WIDTH; i++) begin
            ePrs1[i] = 0; ePrs2[i] = 0; ePrd[i] = 0; ePrev[i] = 0;
            ePv[i] = 0; eCp[i] = 0; eBr[i] = 0;
        end
    endtask

    task automatic clearInputs();
        in_valid = 0; rs1 = '0; rs2 = '0; rd = '0; rd_valid = '0; is_br = '0;
        free_prd = '0; recover = 0; recover_idx = '0; retire_cp = 0;
    endtask

    task automatic setLane(input int l, input int r1, input int r2, input int d,
                           input int dv, input int br, input int fp);
        rs1[l*AW +: AW]      = AW'(r1);
        rs2[l*AW +: AW]      = AW'(r2);
        rd[l*AW +: AW]       = AW'(d);
        rd_valid[l]          = (dv != 0);
        is_br[l]             = (br != 0);
        free_prd[l*PW +: PW] = PW'(fp);
    endtask

    task automatic doReset();
        reset = 1;
        clearInputs();
        #2;
        modelReset();
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_cp_count", cp_count, 0);
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_prs1", prs1, 0);
        checkOutput("rst_prs2", prs2, 0);
        checkOutput("rst_prd", prd, 0);
        checkOutput("rst_prev_prd", prev_prd, 0);
        checkOutput("rst_prev_valid", prev_valid, 0);
        checkOutput("rst_cp_idx", cp_idx, 0);
        reset = 0;
        #1;
    endtask

    // One clock: check the combinational handshake, advance the model, then
    // compare the registered outputs just after the edge.
    task automatic applyStimulus();
        int nb, ready, fire, retEff, k, d, ri, r1, r2, fp, we, slot;
        int tmp [ARF_N];
        #1;
        nb = 0;
        for (int i = 0; i < WIDTH; i++) nb += is_br[i] ? 1 : 0;
        ready = (!recover && (CP_DEPTH - mCount >= nb)) ? 1 : 0;
        checkOutput("in_ready", in_ready, ready);
        checkOutput("cp_count_pre", cp_count, mCount);
        fire   = (in_valid && ready) ? 1 : 0;
        retEff = (retire_cp && mCount > 0) ? 1 : 0;
        k = 0;
        if (fire != 0) begin
            tmp = mMap;
            for (int i = 0; i < WIDTH; i++) begin
                r1 = rs1[i*AW +: AW];
                r2 = rs2[i*AW +: AW];
                d  = rd[i*AW +: AW];
                fp = free_prd[i*PW +: PW];
                we = (rd_valid[i] && d != 0) ? 1 : 0;
                ePrs1[i] = (r1 == 0) ? 0 : tmp[r1];
                ePrs2[i] = (r2 == 0) ? 0 : tmp[r2];
                ePrev[i] = tmp[d];
                ePv[i]   = we;
                if (we != 0) begin
                    tmp[d]  = fp;
                    ePrd[i] = fp;
                end
                eBr[i] = is_br[i] ? 1 : 0;
                if (is_br[i]) begin
                    slot      = (mTail + k) % CP_DEPTH;
                    mCp[slot] = tmp;
                    eCp[i]    = slot;
                    k++;
                end
            end
            mMap  = tmp;
            mTail = (mTail + k) % CP_DEPTH;
        end
        if (retEff != 0) mHead = (mHead + 1) % CP_DEPTH;
        if (recover) begin
            ri = recover_idx;
            d  = ((ri - mHead + 1) % CP_DEPTH + CP_DEPTH) % CP_DEPTH;
            mCount = (d == 0 && retEff == 0) ? CP_DEPTH : d;
            mMap   = mCp[ri];
            mTail  = (ri + 1) % CP_DEPTH;
        end else begin
            mCount = mCount - retEff + k;
        end
        eOv = fire;
        @(posedge clock);
        #1;
        checkOutput("out_valid", out_valid, eOv);
        checkOutput("cp_count", cp_count, mCount);
        for (int i = 0; i < WIDTH; i++) begin
            checkOutput($sformatf("prs1[%0d]", i), prs1[i*PW +: PW], ePrs1[i]);
            checkOutput($sformatf("prs2[%0d]", i), prs2[i*PW +: PW], ePrs2[i]);
            checkOutput($sformatf("prev_valid[%0d]", i), prev_valid[i], ePv[i]);
            if (ePv[i] != 0) begin
                checkOutput($sformatf("prd[%0d]", i), prd[i*PW +: PW], ePrd[i]);
                checkOutput($sformatf("prev_prd[%0d]", i), prev_prd[i*PW +: PW], ePrev[i]);
            end
            if (eBr[i] != 0) begin
                checkOutput($sformatf("cp_idx[%0d]", i), cp_idx[i*CW +: CW], eCp[i]);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        reset = 1;
        doReset();

        // Simple rename with in-group bypass of x5
        clearInputs(); in_valid = 1;
        setLane(0, 0, 0, 5, 1, 0, 40);
        setLane(1, 5, 0, 0, 0, 0, 0);
        applyStimulus();
        checkOutput("req21_prs1_l1", prs1[PW +: PW], 40);
        checkOutput("req21_prev_l0", prev_prd[0 +: PW], 5);
        checkOutput("req21_out_valid", out_valid, 1);
        clearInputs();
        applyStimulus();
        checkOutput("pulse_out_valid", out_valid, 0);

        // Same destination in both lanes: the higher lane wins
        clearInputs(); in_valid = 1;
        setLane(0, 0, 0, 7, 1, 0, 41);
        setLane(1, 0, 0, 7, 1, 0, 42);
        applyStimulus();
        checkOutput("req22_prev_l1", prev_prd[PW +: PW], 41);
        clearInputs(); in_valid = 1;
        setLane(0, 7, 5, 0, 0, 0, 0);
        applyStimulus();
        checkOutput("req22_prs1_x7", prs1[0 +: PW], 42);

        // Writes to x0 are ignored
        clearInputs(); in_valid = 1;
        setLane(0, 0, 0, 0, 1, 0, 50);
        applyStimulus();
        checkOutput("req23_prev_valid", prev_valid[0], 0);
        clearInputs(); in_valid = 1;
        setLane(0, 0, 0, 0, 0, 0, 0);
        setLane(1, 0, 0, 0, 0, 0, 0);
        applyStimulus();
        checkOutput("req23_prs1_x0", prs1[0 +: PW], 0);

        // Fill the checkpoint ring, stall, then retire to unblock
        for (int g = 0; g < 4; g++) begin
            clearInputs(); in_valid = 1;
            setLane(0, 1, 2, 10 + g, 1, 1, 20 + g);
            applyStimulus();
        end
        clearInputs(); in_valid = 1;
        setLane(0, 0, 0, 0, 0, 1, 0);
        #1;
        checkOutput("req24_in_ready_full", in_ready, 0);
        checkOutput("req24_cp_count_full", cp_count, 4);
        retire_cp = 1;
        applyStimulus();
        retire_cp = 0;
        #1;
        checkOutput("req24_in_ready_after_retire", in_ready, 1);
        applyStimulus();

        // Recover to slot 1 restores x3
        doReset();
        clearInputs(); in_valid = 1; setLane(0, 0, 0, 0, 0, 1, 0);
        applyStimulus();
        clearInputs(); in_valid = 1; setLane(0, 0, 0, 0, 0, 1, 0);
        applyStimulus();
        checkOutput("req25_cp_idx_slot1", cp_idx[0 +: CW], 1);
        clearInputs(); in_valid = 1; setLane(0, 0, 0, 3, 1, 0, 45);
        applyStimulus();
        clearInputs(); in_valid = 1; recover = 1; recover_idx = 2'd1;
        setLane(0, 3, 0, 0, 0, 0, 0);
        applyStimulus();
        checkOutput("req25_cp_count", cp_count, 2);
        checkOutput("req25_out_valid", out_valid, 0);
        clearInputs(); in_valid = 1; setLane(0, 3, 0, 0, 0, 0, 0);
        applyStimulus();
        checkOutput("req25_prs1_x3", prs1[0 +: PW], 3);

        // Reset while a group is pending: no output, identity map afterwards
        clearInputs(); in_valid = 1; setLane(0, 0, 0, 5, 1, 0, 60);
        #2;
        reset = 1;
        @(posedge clock);
        #1;
        checkOutput("req26_out_valid", out_valid, 0);
        reset = 0;
        modelReset();
        clearInputs(); in_valid = 1;
        setLane(0, 5, 7, 0, 0, 0, 0);
        applyStimulus();
        checkOutput("req26_prs1_x5", prs1[0 +: PW], 5);
        checkOutput("req26_prs2_x7", prs2[0 +: PW], 7);

        // Randomized groups
        for (int c = 0; c < 400; c++) begin
            int lim;
            clearInputs();
            lim = (c % 2 == 0) ? 7 : 31;
            in_valid = ($urandom_range(0, 9) < 7);
            for (int l = 0; l < WIDTH; l++) begin
                setLane(l, $urandom_range(0, lim), $urandom_range(0, lim),
                        $urandom_range(0, lim), $urandom_range(0, 3) != 0,
                        $urandom_range(0, 3) == 0, $urandom_range(1, PRF_N - 1));
            end
            retire_cp = ($urandom_range(0, 4) == 0);
            if (mCount > 0 && $urandom_range(0, 14) == 0) begin
                recover     = 1;
                recover_idx = CW'((mHead + int'($urandom_range(0, mCount - 1))) % CP_DEPTH);
            end
            applyStimulus();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
